// File: rtl/prim_pulse_pacer_if.sv
// prim_pulse_pacer_if: event input, paced output and status of the pulse pacer (drop_cnt_o with PRIM_PULSE_PACER_DROP_CNT_EN)
interface prim_pulse_pacer_if #(parameter int CntWidth = 4);
  logic                pulse_i;
  logic                clr_overflow_i;
  logic                pulse_o;
  logic [CntWidth-1:0] pending_o;
  logic                busy_o;
  logic                overflow_o;
`ifdef PRIM_PULSE_PACER_DROP_CNT_EN
  logic [7:0]          drop_cnt_o;
  modport master (output pulse_i, clr_overflow_i, input pulse_o, pending_o, busy_o, overflow_o, drop_cnt_o);
  modport slave  (input pulse_i, clr_overflow_i, output pulse_o, pending_o, busy_o, overflow_o, drop_cnt_o);
`else
  modport master (output pulse_i, clr_overflow_i, input pulse_o, pending_o, busy_o, overflow_o);
  modport slave  (input pulse_i, clr_overflow_i, output pulse_o, pending_o, busy_o, overflow_o);
`endif
endinterface

// File: rtl/prim_pulse_pacer.sv
// prim_pulse_pacer: queues event pulses and replays them GapCycles apart; PRIM_PULSE_PACER_DROP_CNT_EN adds a drop counter
module prim_pulse_pacer #(
  parameter int CntWidth  = 4,
  parameter int GapCycles = 6
) (
  input logic              clk_i,
  input logic              rst_i,
  prim_pulse_pacer_if.slave bus
);
  localparam int GW = $clog2(GapCycles);
  if (GapCycles < 2 || CntWidth < 1) begin : g_param_err
    $error("prim_pulse_pacer: GapCycles must be >= 2 and CntWidth >= 1");
  end
  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_e;
  state_e              state_q, state_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [CntWidth-1:0] pending_q, pending_d;
  logic                pulse_q, pulse_d, overflow_q, overflow_d;
  logic                inc, dec, drop;
  always_comb begin
    dec        = state_q == EMIT;
    drop       = bus.pulse_i && pending_q == '1 && !dec;
    inc        = bus.pulse_i && !drop;
    pending_d  = pending_q + CntWidth'(inc) - CntWidth'(dec);
    overflow_d = drop || (overflow_q && !bus.clr_overflow_i);
    gap_d      = state_q == EMIT ? GW'(GapCycles - 2) :
                 (state_q == GAP && gap_q != '0) ? gap_q - GW'(1) : gap_q;
    state_d    = state_q == EMIT ? GAP :
                 state_q == GAP  ? (gap_q != '0 ? GAP : pending_d != '0 ? EMIT : IDLE) :
                 (pending_q != '0 ? EMIT : IDLE);
    pulse_d    = state_d == EMIT;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      pending_q  <= '0;
      pulse_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      pending_q  <= pending_d;
      pulse_q    <= pulse_d;
      overflow_q <= overflow_d;
    end
  end
  assign bus.pulse_o    = pulse_q;
  assign bus.pending_o  = pending_q;
  assign bus.busy_o     = state_q != IDLE || pending_q != '0;
  assign bus.overflow_o = overflow_q;
`ifdef PRIM_PULSE_PACER_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  always_comb begin
    drop_cnt_d = drop ? (bus.clr_overflow_i ? 8'd1 : drop_cnt_q + {7'd0, drop_cnt_q != 8'hff}) :
                 bus.clr_overflow_i ? 8'd0 : drop_cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) drop_cnt_q <= 8'd0;
    else       drop_cnt_q <= drop_cnt_d;
  end
  assign bus.drop_cnt_o = drop_cnt_q;
`endif
`ifdef INC_ASSERT
  localparam int SW = $clog2(GapCycles + 1);
  logic [SW-1:0] since_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                        since_q <= SW'(GapCycles);
    else if (pulse_q)                 since_q <= SW'(1);
    else if (since_q != SW'(GapCycles)) since_q <= since_q + SW'(1);
  end
  a_one_cycle: assert property (@(posedge clk_i) disable iff (rst_i) pulse_q |=> !pulse_q);
  a_spacing:   assert property (@(posedge clk_i) disable iff (rst_i) pulse_q |-> since_q == SW'(GapCycles));
  a_pending:   assert property (@(posedge clk_i) disable iff (rst_i) state_q == EMIT |-> pending_q != '0);
`endif
endmodule

// File: tb/tb_prim_pulse_pacer.sv
// tb_prim_pulse_pacer: random event traffic into two pacer configurations, checked against a timeline model
module tb_prim_pulse_pacer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pulse = 1'b0;
  logic clr = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  always #5 clk = ~clk;

  prim_pulse_pacer_if #(.CntWidth(4)) if0 ();
  prim_pulse_pacer_if #(.CntWidth(2)) if1 ();
  assign if0.pulse_i = pulse;
  assign if0.clr_overflow_i = clr;
  assign if1.pulse_i = pulse;
  assign if1.clr_overflow_i = clr;

  prim_pulse_pacer #(.CntWidth(4), .GapCycles(6)) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
  prim_pulse_pacer #(.CntWidth(2), .GapCycles(3)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: pending count P per cycle; an emission happens exactly G cycles after the
  // previous one if work is pending then, otherwise one cycle after work appears while idle.
  int mx[2]  = '{15, 3};
  int gap[2] = '{6, 3};
  int p[2], prev_p[2], last[2], ovf[2], dcnt[2];
  int cyc = 0;

  function automatic int obs_of(input int k, input int which);
    case (which)
      0: obs_of = k == 0 ? int'(if0.pulse_o) : int'(if1.pulse_o);
      1: obs_of = k == 0 ? int'(if0.pending_o) : int'(if1.pending_o);
      2: obs_of = k == 0 ? int'(if0.busy_o) : int'(if1.busy_o);
      3: obs_of = k == 0 ? int'(if0.overflow_o) : int'(if1.overflow_o);
`ifdef PRIM_PULSE_PACER_DROP_CNT_EN
      4: obs_of = k == 0 ? int'(if0.drop_cnt_o) : int'(if1.drop_cnt_o);
`endif
      default: obs_of = 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      p[k] = 0; prev_p[k] = 0; last[k] = cyc - 100; ovf[k] = 0; dcnt[k] = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s%0d.pulse", tag, k), obs_of(k, 0), 0);
      check($sformatf("%s%0d.pending", tag, k), obs_of(k, 1), 0);
      check($sformatf("%s%0d.busy", tag, k), obs_of(k, 2), 0);
      check($sformatf("%s%0d.overflow", tag, k), obs_of(k, 3), 0);
    end
  endtask

  task automatic step_and_check();
    for (int k = 0; k < 2; k++) begin
      bit emit, busy, drop, inc;
      emit = (cyc == last[k] + gap[k] && p[k] > 0) || (cyc > last[k] + gap[k] && prev_p[k] > 0);
      busy = p[k] > 0 || emit || cyc < last[k] + gap[k];
      check($sformatf("i%0d.pulse_o", k), obs_of(k, 0), int'(emit));
      check($sformatf("i%0d.pending_o", k), obs_of(k, 1), p[k]);
      check($sformatf("i%0d.busy_o", k), obs_of(k, 2), int'(busy));
      check($sformatf("i%0d.overflow_o", k), obs_of(k, 3), ovf[k]);
`ifdef PRIM_PULSE_PACER_DROP_CNT_EN
      check($sformatf("i%0d.drop_cnt_o", k), obs_of(k, 4), dcnt[k]);
`endif
      drop = pulse && p[k] == mx[k] && !emit;
      inc  = pulse && !drop;
      if (emit) last[k] = cyc;
      prev_p[k] = p[k];
      p[k] = p[k] + int'(inc) - int'(emit);
      ovf[k] = int'(drop || (ovf[k] != 0 && !clr));
      dcnt[k] = drop ? (clr ? 1 : (dcnt[k] < 255 ? dcnt[k] + 1 : 255)) : (clr ? 0 : dcnt[k]);
    end
    cyc++;
  endtask

  initial begin
    #1 check_reset_outputs("rst_init");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    step_and_check();
    for (int i = 0; i < 4000; i++) begin
      int phase;
      phase = (i / 400) % 4;
      @(posedge clk);
      #1;
      if (i > 0 && $urandom_range(0, 499) == 0) begin
        rst = 1'b1; pulse = 1'b0; clr = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        step_and_check();
        continue;
      end
      case (phase)
        0: pulse = $urandom_range(0, 19) == 0;
        1: pulse = $urandom_range(0, 2) == 0;
        2: pulse = 1'b1;
        default: pulse = $urandom_range(0, 1) == 0;
      endcase
      clr = phase != 2 && $urandom_range(0, 49) == 0;
      @(negedge clk);
      step_and_check();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
